// File: rtl/cache_control.sv
// cache_control: N-way set-associative write-back cache controller.
// Owns tag/valid/dirty/round-robin metadata and sequences hits, dirty-line
// write-backs and line fills. The line data array lives outside this block;
// it is steered through way_sel, data_load and data_src_sel.
//
// Handshakes: the CPU holds mem_read/mem_write (and mem_address) as levels
// until it sees the one-cycle mem_resp pulse, then drops them the next cycle.
// pmem_read/pmem_write are held, with a stable pmem_address, until pmem_resp
// is sampled high; they fall the following cycle. pmem_resp outside
// WRITEBACK/FILL is ignored.
module cache_control #(
  parameter int ADDR_WIDTH  = 16,
  parameter int OFFSET_BITS = 5,
  parameter int INDEX_BITS  = 3,
  parameter int WAYS        = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [ADDR_WIDTH-1:0]                     mem_address,
  input  logic                                      mem_read,
  input  logic                                      mem_write,
  output logic                                      mem_resp,
  output logic [ADDR_WIDTH-1:0]                     pmem_address,
  output logic                                      pmem_read,
  output logic                                      pmem_write,
  input  logic                                      pmem_resp,
  output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] way_sel,
  output logic                                      data_load,
  output logic                                      data_src_sel,
  output logic                                      hit,
  output logic [1:0]                                dbg_state_o
);

  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int WB       = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int SETS     = 1 << INDEX_BITS;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_CHECK     = 2'd1;
  localparam logic [1:0] S_WRITEBACK = 2'd2;
  localparam logic [1:0] S_FILL      = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [WB-1:0]       victim_q, victim_d;
  logic                vic_rr_q, vic_rr_d;   // victim was chosen by rr

  logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     dirty_q [SETS];
  logic [WB-1:0]       rr_q    [SETS];

  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_idx;
  logic                  unused_offset;

  logic          hit_any, inv_any;
  logic [WB-1:0] hit_way, inv_way, way_int;
  logic          set_dirty, clr_dirty, fill_en;

  assign req_tag       = mem_address[ADDR_WIDTH-1 -: TAG_BITS];
  assign req_idx       = mem_address[OFFSET_BITS +: INDEX_BITS];
  assign unused_offset = ^mem_address[OFFSET_BITS-1:0];

  // Tag lookup: descending scan so the lowest matching / invalid way wins.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = WB'(w);
      end
      if (!valid_q[req_idx][w]) begin
        inv_any = 1'b1;
        inv_way = WB'(w);
      end
    end
  end

  // Control FSM: next state, outputs and metadata update strobes.
  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    vic_rr_d     = vic_rr_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    way_int      = '0;
    data_load    = 1'b0;
    data_src_sel = 1'b0;
    set_dirty    = 1'b0;
    clr_dirty    = 1'b0;
    fill_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_read || mem_write) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (hit_any) begin
          way_int  = hit_way;
          mem_resp = 1'b1;
          // A write wins when both requests are raised.
          if (mem_write) begin
            data_load = 1'b1;
            set_dirty = 1'b1;
          end
          state_d = S_IDLE;
        end else begin
          victim_d = inv_any ? inv_way : rr_q[req_idx];
          vic_rr_d = !inv_any;
          if (valid_q[req_idx][victim_d] && dirty_q[req_idx][victim_d])
            state_d = S_WRITEBACK;
          else
            state_d = S_FILL;
        end
      end
      S_WRITEBACK: begin
        way_int      = victim_q;
        pmem_write   = 1'b1;
        pmem_address = {tag_q[req_idx][victim_q], req_idx, {OFFSET_BITS{1'b0}}};
        if (pmem_resp) begin
          clr_dirty = 1'b1;
          state_d   = S_FILL;
        end
      end
      S_FILL: begin
        way_int      = victim_q;
        pmem_read    = 1'b1;
        pmem_address = {req_tag, req_idx, {OFFSET_BITS{1'b0}}};
        if (pmem_resp) begin
          data_load    = 1'b1;
          data_src_sel = 1'b1;
          fill_en      = 1'b1;
          state_d      = S_CHECK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign hit         = (state_q == S_CHECK) && hit_any;
  assign way_sel     = (WAYS == 1) ? '0 : way_int;
  assign dbg_state_o = state_q;

  // FSM state and registered victim choice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      victim_q <= '0;
      vic_rr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      vic_rr_q <= vic_rr_d;
    end
  end

  // Valid, dirty and round-robin metadata; reset wipes all lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      if (set_dirty) dirty_q[req_idx][hit_way]  <= 1'b1;
      if (clr_dirty) dirty_q[req_idx][victim_q] <= 1'b0;
      if (fill_en) begin
        valid_q[req_idx][victim_q] <= 1'b1;
        dirty_q[req_idx][victim_q] <= 1'b0;
        if (vic_rr_q && (WAYS > 1)) rr_q[req_idx] <= rr_q[req_idx] + WB'(1);
      end
    end
  end

  // Tag store; contents are meaningless while the matching valid bit is 0.
  always_ff @(posedge clk) begin
    if (fill_en) tag_q[req_idx][victim_q] <= req_tag;
  end

endmodule
